// File: rtl/mmu_l2tlb_pkg.sv
// Shared definitions for the L2 TLB tree pseudo-LRU engine: width helper,
// heap-indexed tree navigation and victim-source encoding.
package mmu_l2tlb_pkg;

  localparam int unsigned PLRU_WAYS_DEFAULT = 4;
  localparam int unsigned PLRU_NODES        = PLRU_WAYS_DEFAULT - 1;

  typedef enum logic {
    SRC_TREE    = 1'b0,
    SRC_INVALID = 1'b1
  } victim_src_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned plru_nodes(input int unsigned ways);
    return ways - 1;
  endfunction

  function automatic int unsigned plru_parent(input int unsigned n);
    return n >> 1;
  endfunction

  function automatic int unsigned plru_lchild(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned plru_rchild(input int unsigned n);
    return 2 * n + 1;
  endfunction

  // Bit written into the parent of heap node 'child' when the access path
  // passes through it: 1 steers future victims away from the lower subtree.
  function automatic logic plru_path_bit(input int unsigned child);
    return ~child[0];
  endfunction

endpackage

// File: rtl/mmu_plru_tree_walk.sv
// Combinational victim selection: lowest invalid way if any, otherwise the
// leaf reached by walking the PLRU tree from the root.
module mmu_plru_tree_walk
  import mmu_l2tlb_pkg::*;
#(
  parameter  int unsigned WAYS  = 4,
  localparam int unsigned WAY_W = clog2(WAYS),
  localparam int unsigned NODES = plru_nodes(WAYS)
) (
  input  logic [NODES-1:0] state_i,
  input  logic [WAYS-1:0]  valid_i,
  output logic [WAYS-1:0]  way_o,
  output logic [WAY_W-1:0] idx_o,
  output logic             from_inv_o
);

  logic [WAY_W-1:0] node;
  logic             found;
  victim_src_e      src;

  always_comb begin
    node  = WAY_W'(1);
    found = 1'b0;
    src   = SRC_TREE;
    idx_o = '0;
    if (valid_i != '1) begin
      src = SRC_INVALID;
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (!found && !valid_i[w]) begin
          idx_o = WAY_W'(w);
          found = 1'b1;
        end
      end
    end else begin
      // Heap node n lives at state bit n-1; the leading 1 shifts out on the
      // final step, leaving the leaf's way index in node.
      for (int unsigned l = 0; l < WAY_W; l++) begin
        node = WAY_W'({node, state_i[node - 1'b1]});
      end
      idx_o = node;
    end
  end

  assign from_inv_o = (src == SRC_INVALID);

  always_comb begin
    way_o        = '0;
    way_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/mmu_l2tlb_plru_nway.sv
// Per-set tree pseudo-LRU state for the L2 TLB with registered victim lookup,
// same-set write-first bypass and single-cycle global flush.
module mmu_l2tlb_plru_nway
  import mmu_l2tlb_pkg::*;
#(
  parameter  int unsigned WAYS  = 4,
  parameter  int unsigned SETS  = 16,
  localparam int unsigned SET_W = (SETS > 1) ? clog2(SETS) : 1,
  localparam int unsigned WAY_W = clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_upd_vld,
  input  logic [SET_W-1:0] i_upd_set,
  input  logic [WAYS-1:0]  i_upd_way,
  input  logic             i_lkp_vld,
  input  logic [SET_W-1:0] i_lkp_set,
  input  logic [WAYS-1:0]  i_lkp_valid_ways,
  output logic             o_victim_vld,
  output logic [WAYS-1:0]  o_victim_way,
  output logic [WAY_W-1:0] o_victim_idx,
  output logic             o_victim_from_inv,
  output logic             o_err_multihot
);

  localparam int unsigned NODES = plru_nodes(WAYS);

  logic [NODES-1:0] state_q [SETS];

  logic             upd_onehot, upd_multi, upd_in_range, upd_ok, lkp_in_range;
  logic [WAY_W-1:0] upd_idx, parent;
  logic [WAY_W:0]   node;
  logic [NODES-1:0] upd_cur, upd_nxt, lkp_cur, lkp_state;
  logic [WAYS-1:0]  walk_way;
  logic [WAY_W-1:0] walk_idx;
  logic             walk_inv;

  logic             victim_vld_q, victim_inv_q, err_q;
  logic [WAYS-1:0]  victim_way_q;
  logic [WAY_W-1:0] victim_idx_q;

  assign upd_onehot   = $onehot(i_upd_way);
  assign upd_multi    = (i_upd_way != '0) && !upd_onehot;
  assign upd_in_range = (32'(i_upd_set) < SETS);
  assign lkp_in_range = (32'(i_lkp_set) < SETS);
  assign upd_ok       = i_upd_vld && upd_onehot && upd_in_range && !i_flush;

  always_comb begin
    upd_idx = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (i_upd_way[w]) upd_idx = upd_idx | WAY_W'(w);
    end
    upd_cur = '0;
    lkp_cur = '0;
    for (int unsigned s = 0; s < SETS; s++) begin
      if (SET_W'(s) == i_upd_set) upd_cur = state_q[s];
      if (SET_W'(s) == i_lkp_set) lkp_cur = state_q[s];
    end
  end

  // Climb from the accessed leaf (heap index WAYS+idx) to the root, marking
  // each ancestor to point away from the side just used.
  always_comb begin
    upd_nxt = upd_cur;
    node    = {1'b1, upd_idx};
    parent  = '0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      parent                   = WAY_W'(plru_parent(32'(node)));
      upd_nxt[parent - 1'b1]   = plru_path_bit(32'(node));
      node                     = {1'b0, parent};
    end
  end

  always_comb begin
    if (i_flush || !lkp_in_range)                lkp_state = '0;
    else if (upd_ok && (i_lkp_set == i_upd_set)) lkp_state = upd_nxt;
    else                                         lkp_state = lkp_cur;
  end

  mmu_plru_tree_walk #(.WAYS(WAYS)) u_walk (
    .state_i    (lkp_state),
    .valid_i    (i_lkp_valid_ways),
    .way_o      (walk_way),
    .idx_o      (walk_idx),
    .from_inv_o (walk_inv)
  );

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      for (int unsigned s = 0; s < SETS; s++) state_q[s] <= '0;
    end else if (upd_ok) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        if (SET_W'(s) == i_upd_set) state_q[s] <= upd_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      victim_vld_q <= 1'b0;
      victim_way_q <= '0;
      victim_idx_q <= '0;
      victim_inv_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      victim_vld_q <= i_lkp_vld;
      err_q        <= i_upd_vld && upd_multi && upd_in_range && !i_flush;
      if (i_lkp_vld) begin
        victim_way_q <= walk_way;
        victim_idx_q <= walk_idx;
        victim_inv_q <= walk_inv;
      end
    end
  end

  assign o_victim_vld      = victim_vld_q;
  assign o_victim_way      = victim_way_q;
  assign o_victim_idx      = victim_idx_q;
  assign o_victim_from_inv = victim_inv_q;
  assign o_err_multihot    = err_q;

endmodule

// File: tb/tb_mmu_l2tlb_plru_nway.sv
// Scoreboard bench for the 8-way, 4-set PLRU engine: a top-down range model
// predicts each victim, which is queued at drive time and compared on output.
module tb_mmu_l2tlb_plru_nway;

  localparam int unsigned WAYS = 8;
  localparam int unsigned SETS = 4;

  logic       clk = 1'b0;
  logic       rst, i_flush, i_upd_vld, i_lkp_vld;
  logic [1:0] i_upd_set, i_lkp_set;
  logic [7:0] i_upd_way, i_lkp_valid_ways;
  logic       o_victim_vld, o_victim_from_inv, o_err_multihot;
  logic [7:0] o_victim_way;
  logic [2:0] o_victim_idx;

  always #5 clk = ~clk;

  mmu_l2tlb_plru_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_flush           (i_flush),
    .i_upd_vld         (i_upd_vld),
    .i_upd_set         (i_upd_set),
    .i_upd_way         (i_upd_way),
    .i_lkp_vld         (i_lkp_vld),
    .i_lkp_set         (i_lkp_set),
    .i_lkp_valid_ways  (i_lkp_valid_ways),
    .o_victim_vld      (o_victim_vld),
    .o_victim_way      (o_victim_way),
    .o_victim_idx      (o_victim_idx),
    .o_victim_from_inv (o_victim_from_inv),
    .o_err_multihot    (o_err_multihot)
  );

  typedef struct {
    logic [7:0] way;
    logic [2:0] idx;
    logic       inv;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mstate [SETS];  // bit n holds heap node n; bit 0 unused
  logic [7:0] last_way;
  logic [2:0] last_idx;
  logic       last_inv;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_apply(input logic [7:0] s, input int unsigned w);
    int unsigned lo, hi, node, mid;
    lo = 0; hi = WAYS; node = 1;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin s[node] = 1'b1; node = 2 * node;     hi = mid; end
      else         begin s[node] = 1'b0; node = 2 * node + 1; lo = mid; end
    end
    return s;
  endfunction

  function automatic exp_t m_victim(input logic [7:0] s, input logic [7:0] valid);
    exp_t        e;
    int unsigned lo, hi, node, mid, v;
    v = 0;
    if (valid != 8'hFF) begin
      for (int i = 7; i >= 0; i--) if (!valid[i]) v = i;
      e.inv = 1'b1;
    end else begin
      lo = 0; hi = WAYS; node = 1;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (s[node] == 1'b0) begin node = 2 * node;     hi = mid; end
        else                 begin node = 2 * node + 1; lo = mid; end
      end
      v = lo;
      e.inv = 1'b0;
    end
    e.idx = 3'(v);
    e.way = 8'(1 << v);
    return e;
  endfunction

  task automatic step(input logic r, input logic fl, input logic uv, input logic [1:0] us,
                      input logic [7:0] uw, input logic lv, input logic [1:0] ls,
                      input logic [7:0] lvw);
    logic [7:0]  ls_state;
    logic        exp_err;
    int          nhot;
    int unsigned uidx;
    exp_t        e;
    @(negedge clk);
    rst = r; i_flush = fl; i_upd_vld = uv; i_upd_set = us; i_upd_way = uw;
    i_lkp_vld = lv; i_lkp_set = ls; i_lkp_valid_ways = lvw;
    nhot = $countones(uw);
    uidx = 0;
    for (int i = 0; i < 8; i++) if (uw[i]) uidx = i;
    exp_err = 1'b0;
    if (r) begin
      for (int s = 0; s < SETS; s++) mstate[s] = '0;
      last_way = '0; last_idx = '0; last_inv = 1'b0;
      sb_q.delete();
    end else begin
      if (fl)                                ls_state = '0;
      else if (uv && nhot == 1 && us == ls)  ls_state = m_apply(mstate[ls], uidx);
      else                                   ls_state = mstate[ls];
      if (lv) sb_q.push_back(m_victim(ls_state, lvw));
      exp_err = uv && (nhot > 1) && !fl;
      if (fl) for (int s = 0; s < SETS; s++) mstate[s] = '0;
      else if (uv && nhot == 1) mstate[us] = m_apply(mstate[us], uidx);
    end
    @(posedge clk);
    #1;
    chk("victim_vld", 32'(o_victim_vld), 32'(lv && !r));
    if (o_victim_vld && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      last_way = e.way; last_idx = e.idx; last_inv = e.inv;
    end
    chk("victim_way", 32'(o_victim_way), 32'(last_way));
    chk("victim_idx", 32'(o_victim_idx), 32'(last_idx));
    chk("victim_inv", 32'(o_victim_from_inv), 32'(last_inv));
    chk("err_multihot", 32'(o_err_multihot), 32'(exp_err));
  endtask

  task automatic idle();
    step(0, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'hFF);
  endtask

  task automatic lookup(input logic [1:0] s, input logic [7:0] valid);
    step(0, 0, 0, 2'd0, 8'h00, 1, s, valid);
  endtask

  task automatic update(input logic [1:0] s, input logic [7:0] w);
    step(0, 0, 1, s, w, 0, 2'd0, 8'hFF);
  endtask

  initial begin
    logic [7:0] rw;
    rst = 1'b1; i_flush = 1'b0; i_upd_vld = 1'b0; i_upd_set = '0; i_upd_way = '0;
    i_lkp_vld = 1'b0; i_lkp_set = '0; i_lkp_valid_ways = 8'hFF;
    step(1, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'hFF);
    step(1, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'hFF);
    chk("reset_vld", 32'(o_victim_vld), 32'h0);
    chk("reset_way", 32'(o_victim_way), 32'h0);

    lookup(2'd0, 8'hFF);
    chk("t1_way", 32'(o_victim_way), 32'h01);
    chk("t1_idx", 32'(o_victim_idx), 32'h0);

    update(2'd0, 8'h01);
    lookup(2'd0, 8'hFF);
    chk("t2a_way", 32'(o_victim_way), 32'h10);
    chk("t2a_idx", 32'(o_victim_idx), 32'h4);
    idle();
    chk("hold_way", 32'(o_victim_way), 32'h10);
    update(2'd0, 8'h10);
    lookup(2'd0, 8'hFF);
    chk("t2b_way", 32'(o_victim_way), 32'h04);
    chk("t2b_idx", 32'(o_victim_idx), 32'h2);
    lookup(2'd1, 8'hFF);
    chk("t2c_way", 32'(o_victim_way), 32'h01);

    step(0, 0, 1, 2'd1, 8'h01, 1, 2'd1, 8'hFF);
    chk("t3_bypass", 32'(o_victim_way), 32'h10);
    step(0, 0, 1, 2'd1, 8'h01, 1, 2'd0, 8'hFF);
    chk("t3_other", 32'(o_victim_way), 32'h04);

    update(2'd2, 8'h20);
    lookup(2'd2, 8'hF7);
    chk("t4_way", 32'(o_victim_way), 32'h08);
    chk("t4_idx", 32'(o_victim_idx), 32'h3);
    chk("t4_inv", 32'(o_victim_from_inv), 32'h1);

    step(0, 1, 1, 2'd0, 8'h40, 1, 2'd0, 8'hFF);
    chk("t5_flush", 32'(o_victim_way), 32'h01);
    for (int s = 0; s < SETS; s++) begin
      lookup(2'(s), 8'hFF);
      chk("t5_after", 32'(o_victim_way), 32'h01);
    end

    update(2'd0, 8'h01);
    update(2'd0, 8'h03);
    chk("t6_err", 32'(o_err_multihot), 32'h1);
    lookup(2'd0, 8'hFF);
    chk("t6_err_clear", 32'(o_err_multihot), 32'h0);
    chk("t6_state", 32'(o_victim_way), 32'h10);
    step(1, 0, 0, 2'd0, 8'h00, 1, 2'd0, 8'hFF);
    chk("t6_rst_vld", 32'(o_victim_vld), 32'h0);
    lookup(2'd0, 8'hFF);
    chk("t6_rst_state", 32'(o_victim_way), 32'h01);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       rw = 8'h00;
        1:       rw = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7)) | 8'h81;
        default: rw = 8'(1 << $urandom_range(0, 7));
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), rw, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_l2tlb_plru_nway.md
Name: mmu_l2tlb_plru_nway

Overview:
Parametrised tree pseudo-LRU replacement engine for the set-associative L2 TLB. It holds one tree-PLRU state vector per set and updates it on hit or refill. On request it returns a registered one-hot victim way, preferring invalid ways. It sits beside the L2 TLB tag/data arrays and serves the refill path, with a single-cycle global flush for sfence/ASID-wide invalidation.

Parameters:
WAYS, 4, associativity; power of two, >=2; tree has WAYS-1 node bits per set
SETS, 16, number of sets; >=1, need not be a power of two
SET_W, max(1,clog2(SETS)), set index width (derived, localparam)
WAY_W, clog2(WAYS), encoded way index width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_flush  in  1  clear PLRU state of all sets
i_upd_vld  in  1  access/update strobe
i_upd_set  in  SET_W  set being updated
i_upd_way  in  WAYS  one-hot way just accessed
i_lkp_vld  in  1  victim lookup strobe
i_lkp_set  in  SET_W  set to select victim from
i_lkp_valid_ways  in  WAYS  per-way valid bits of the looked-up set
o_victim_vld  out  1  victim result valid (1 cycle after i_lkp_vld)
o_victim_way  out  WAYS  one-hot victim
o_victim_idx  out  WAY_W  encoded victim
o_victim_from_inv  out  1  victim chosen because a way was invalid
o_err_multihot  out  1  one-cycle pulse: last update had multi-hot i_upd_way

Behaviour:
- Reset is synchronous and active-high: clock is clk, reset is rst. On rst: all set state = 0; o_victim_vld=0, o_victim_way=0, o_victim_idx=0, o_victim_from_inv=0, o_err_multihot=0. rst overrides every other input, including a lookup pending in the same cycle.
- Tree encoding: nodes are heap-indexed 1..WAYS-1; node n has children 2n (lower ways) and 2n+1 (upper ways); leaf ways run 0..WAYS-1, left to right.
- Node bit 0 = victim walk goes to the lower child; 1 = goes to the upper child.
- Update (i_upd_vld, i_upd_way exactly one-hot, set < SETS): every node on the path to that way is written at the clock edge. Bit = 1 if the accessed way lies in the lower subtree, 0 if it lies in the upper subtree. Nodes off the path are unchanged.
- i_upd_way all-zero: no-op, no error.
- i_upd_way multi-hot: state unchanged; o_err_multihot=1 on the next cycle only.
- Update with set >= SETS: ignored.
- Lookup: latency 1. o_victim_* registered from i_lkp_vld. o_victim_vld=0 in cycles without a lookup; the other victim outputs hold their last value.
- Invalid preference: if i_lkp_valid_ways != all-ones, the victim is the lowest-index zero bit and o_victim_from_inv=1. Otherwise the victim comes from the tree walk and o_victim_from_inv=0.
- Write-first bypass: if a valid one-hot update and a lookup hit the same set in the same cycle, the victim is computed from the post-update state.
- Lookup with set >= SETS: the victim is computed from all-zero state (way 0, unless a way is invalid).
- Flush: all set state = 0 at the edge. Flush has priority over a same-cycle update; that update is discarded and no error is flagged.
- Lookup concurrent with flush: the victim is computed from all-zero state.
- State storage is flops (SETS*(WAYS-1) bits). There is no SRAM, and flush completes in 1 cycle.
- No backpressure: one lookup and one update are accepted every cycle.

Decomposition:
- Shared package mmu_l2tlb_pkg holds:
  - clog2 function
  - PLRU node-index helpers (parent/child, path-bit computation)
  - the PLRU_NODES = WAYS-1 constant
- Natural sub-module: mmu_plru_tree_walk. It is combinational and maps a WAYS-1 state vector plus a valid mask to victim one-hot, index and from_inv. The top instantiates it once, on the bypass-muxed next-state of the looked-up set.

Test Plan:
1. WAYS=8, SETS=4, reset then lookup set0 with valid=8'hFF -> next cycle o_victim_vld=1, o_victim_way=8'h01, idx=0, from_inv=0.
2. Update set0 way 8'h01 -> lookup set0 gives 8'h10 (idx 4). Then update way 8'h10 -> lookup gives 8'h04 (idx 2). Set1 is untouched and still gives 8'h01.
3. Same cycle: update set1 way 8'h01 and lookup set1 -> victim 8'h10 (bypass). Same cycle with set0 lookup instead -> victim from set0's unchanged state.
4. Lookup set2 with valid=8'hF7 after arbitrary updates -> victim 8'h08, idx 3, from_inv=1.
5. After updates, pulse i_flush together with an update to set0 and a lookup of set0 -> victim 8'h01. All later lookups of any set give 8'h01; the flushed-cycle update had no effect.
6. Update with i_upd_way=8'h03 -> o_err_multihot=1 for exactly one cycle, state unchanged. Then assert rst during a lookup -> o_victim_vld=0 next cycle, all state zero.
